instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Sequencer that reads instruction bytes from program memory at the program counter and feeds the opcode byte to the instruction register. It assembles 0, 1 or 2 trailing operand bytes into an immediate, then holds the complete instruction for the execute/control stage under a valid/ready handshake. It sits between program memory and the instruction register and control unit. It is the only driver of the instruction register's load and data inputs.

## Interface
Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- mem_addr  out  ADDR_WIDTH  program memory read address
- mem_rd  out  1  read strobe; mem_rdata is valid exactly one cycle later
- mem_rdata  in  DATA_WIDTH  program memory read data
- ir_load  out  1  one-cycle load pulse to the instruction register
- ir_data  out  DATA_WIDTH  opcode byte to the instruction register (mem_rdata passthrough)
- imm  out  16  assembled operand bytes, little-endian
- instr_valid  out  1  complete instruction available
- instr_ready  in  1  consumer accepts the instruction
- pc_load  in  1  redirect request (taken jump/call/ret)
- pc_load_addr  in  ADDR_WIDTH  redirect target
- pc  out  ADDR_WIDTH  address of the next byte to fetch
- illegal_op  out  1  undefined opcode trap (see Configuration)

## Operation
- FSM states: FETCH_OP, WAIT_OP, FETCH_B1, WAIT_B1, FETCH_B2, WAIT_B2, PRESENT, TRAP.
- FETCH_OP: mem_rd=1, mem_addr=pc, pc<=pc+1, imm<=0 → WAIT_OP.
- WAIT_OP: ir_load=1, ir_data=mem_rdata. The length is instr_length(opcode), where the opcode is the upper bits of mem_rdata.
  - Length 1 → PRESENT.
  - Length 2 or 3 → FETCH_B1.
- FETCH_B1 / FETCH_B2: mem_rd=1, mem_addr=pc, pc<=pc+1, then go to the matching WAIT state.
- WAIT_B1: imm[7:0]<=mem_rdata.
  - Length 3 → FETCH_B2.
  - Otherwise → PRESENT.
- WAIT_B2: imm[15:8]<=mem_rdata → PRESENT.
- PRESENT: instr_valid=1, with imm held stable.
  - On instr_valid&&instr_ready → FETCH_OP.
  - If pc_load is also high in that cycle, pc<=pc_load_addr.
- pc_load is ignored in every cycle except the PRESENT handshake cycle.
- pc wraps 16'hFFFF → 16'h0000 with no flag. A multi-byte instruction may straddle the wrap.
- mem_rd is 0 in all states other than FETCH_*. ir_load is 0 outside WAIT_OP.

## Timing
- Reset values: pc=RESET_VECTOR, state=FETCH_OP, mem_rd=0, mem_addr=RESET_VECTOR, ir_load=0, imm=0, instr_valid=0, illegal_op=0.
- The first mem_rd occurs in the first cycle after reset deasserts.
- Latency from the FETCH_OP cycle to instr_valid:
  - Length 1: 2 cycles.
  - Length 2: 4 cycles.
  - Length 3: 6 cycles.
- Back-to-back throughput with ready held high: one instruction per (2×length + 1) cycles.
- instr_valid stays high, and imm stays stable, until accepted. instr_ready while not valid has no effect.
- Reset mid-fetch or mid-PRESENT: all in-flight data is discarded and the reset values apply the next cycle. Reset wins over pc_load.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined:
  - An opcode for which is_legal_opcode() is false enters TRAP in place of the length decode.
  - In TRAP: illegal_op=1, instr_valid=0, mem_rd=0, pc frozen at opcode address+1.
  - TRAP is left only by reset.
- FETCH_ILLEGAL_TRAP_EN undefined:
  - Undefined opcodes are treated as length 1 and presented normally.
  - illegal_op is tied to 0 and the TRAP state is not built.

## Structure
- arch_defs_pkg additions:
  - ADDR_WIDTH (16)
  - fetch_state_t enum
  - instr_length(opcode_t) function returning 1..3
  - is_legal_opcode(opcode_t) function
- The opcode_t field positions are shared with the instruction register via instruction_t.
- One sub-module, program_counter: holds the PC and provides reset-to-vector, increment with wrap, and load. The FSM drives its inc/load controls.

## Test plan
- Reset, then memory 0x0000 holds a 1-byte opcode, ready=1 → mem_rd at addr 0 in cycle 1, ir_load in cycle 2, instr_valid in cycle 3, pc=0x0001.
- 3-byte instruction at 0x0010 with bytes [op, 0x34, 0x12] → imm=16'h1234, instr_valid exactly 6 cycles after FETCH_OP, pc=0x0013.
- Hold instr_ready=0 for 5 cycles while valid → instr_valid and imm stable, no mem_rd. Raise ready → next fetch at pc next cycle.
- pc_load=1, pc_load_addr=0x8000 during handshake → next mem_addr=0x8000. pc_load while not in PRESENT → ignored.
- 2-byte instruction at 0xFFFF → operand read from 0x0000, pc=0x0001 after fetch.
- Undefined opcode, macro on → illegal_op=1, no further mem_rd until reset. Macro off → presented as 1-byte, illegal_op=0. Reset asserted in WAIT_B1 → reset values next cycle.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Architecture-wide definitions shared by the fetch sequencer, the instruction
// register and the control unit: widths, opcode layout, fetch states and decode.
package arch_defs_pkg;

  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 8;
  localparam int OPCODE_WIDTH = 5;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  // Opcode occupies the upper bits of an instruction byte; the rest selects a register.
  typedef struct packed {
    opcode_t                                opcode;
    logic [DATA_WIDTH-OPCODE_WIDTH-1:0]     reg_sel;
  } instruction_t;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t FETCH_OP = 3'd0;
  localparam fetch_state_t WAIT_OP  = 3'd1;
  localparam fetch_state_t FETCH_B1 = 3'd2;
  localparam fetch_state_t WAIT_B1  = 3'd3;
  localparam fetch_state_t FETCH_B2 = 3'd4;
  localparam fetch_state_t WAIT_B2  = 3'd5;
  localparam fetch_state_t PRESENT  = 3'd6;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam fetch_state_t TRAP     = 3'd7;
`endif

  typedef logic [1:0] instr_len_t;

  // 0x00-0x0F: 1 byte, 0x10-0x17: 2 bytes, 0x18-0x1D: 3 bytes, 0x1E-0x1F: undefined.
  function automatic instr_len_t instr_length(opcode_t op);
    instr_len_t len;
    if (op < 5'h10)      len = 2'd1;
    else if (op < 5'h18) len = 2'd2;
    else if (op < 5'h1E) len = 2'd3;
    else                 len = 2'd1;
    return len;
  endfunction

  function automatic logic is_legal_opcode(opcode_t op);
    return (op < 5'h1E);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch sequencer and program memory / instruction register /
// control unit. The master side is the fetch sequencer.
interface instruction_fetch_if;
  import arch_defs_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  ir_load;
  logic [DATA_WIDTH-1:0] ir_data;
  logic [15:0]           imm;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_addr;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  illegal_op;

  modport master (
    output mem_addr, mem_rd, ir_load, ir_data, imm, instr_valid, pc, illegal_op,
    input  mem_rdata, instr_ready, pc_load, pc_load_addr
  );

  modport slave (
    input  mem_addr, mem_rd, ir_load, ir_data, imm, instr_valid, pc, illegal_op,
    output mem_rdata, instr_ready, pc_load, pc_load_addr
  );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: reset-to-vector, load, and increment with silent wrap at the
// top of the address space.
module program_counter
  import arch_defs_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset)     pc <= RESET_VECTOR;
    else if (load) pc <= load_addr;
    else if (inc)  pc <= pc + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads opcode plus 0..2 operand bytes and presents the
// instruction under valid/ready. Define FETCH_ILLEGAL_TRAP_EN to trap undefined opcodes.
module instruction_fetch
  import arch_defs_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_t          state, state_next;
  instr_len_t            len_q;
  logic [15:0]           imm_q;
  logic [ADDR_WIDTH-1:0] pc;
  opcode_t               opcode;
  logic                  fetching;
  logic                  handshake;

  // Same bit positions as instruction_t.opcode.
  assign opcode = bus.mem_rdata[$bits(instruction_t)-1 -: $bits(opcode_t)];

  // NOTE: state already sits at FETCH_OP while reset is held, so the read
  // strobe is masked by reset to keep memory quiet until reset is released.
  assign fetching  = ((state == FETCH_OP) || (state == FETCH_B1) || (state == FETCH_B2)) && !reset;
  assign handshake = (state == PRESENT) && bus.instr_ready;

  program_counter #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk       (clk),
    .reset     (reset),
    .inc       (fetching),
    .load      (handshake && bus.pc_load),
    .load_addr (bus.pc_load_addr),
    .pc        (pc)
  );

  assign bus.pc          = pc;
  assign bus.mem_addr    = pc;
  assign bus.mem_rd      = fetching;
  assign bus.ir_load     = (state == WAIT_OP);
  assign bus.ir_data     = bus.mem_rdata;
  assign bus.imm         = imm_q;
  assign bus.instr_valid = (state == PRESENT);
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign bus.illegal_op  = (state == TRAP);
`else
  assign bus.illegal_op  = 1'b0;
`endif

  // NOTE: next-state defaults to the current state first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_OP: state_next = WAIT_OP;
      WAIT_OP: begin
        state_next = (instr_length(opcode) == 2'd1) ? PRESENT : FETCH_B1;
`ifdef FETCH_ILLEGAL_TRAP_EN
        if (!is_legal_opcode(opcode)) state_next = TRAP;
`endif
      end
      FETCH_B1: state_next = WAIT_B1;
      WAIT_B1:  state_next = (len_q == 2'd3) ? FETCH_B2 : PRESENT;
      FETCH_B2: state_next = WAIT_B2;
      WAIT_B2:  state_next = PRESENT;
      PRESENT:  if (bus.instr_ready) state_next = FETCH_OP;
`ifdef FETCH_ILLEGAL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_OP;
      len_q <= 2'd1;
      imm_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        FETCH_OP: imm_q       <= '0;
        WAIT_OP:  len_q       <= instr_length(opcode);
        WAIT_B1:  imm_q[7:0]  <= bus.mem_rdata;
        WAIT_B2:  imm_q[15:8] <= bus.mem_rdata;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table of instructions with a
// scoreboard, plus hand-written sequences for stall, redirect, wrap, illegal opcode and reset.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_VECTOR(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program memory: data valid one cycle after the read strobe.
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0, b1, b2;
    int          len;
    logic [15:0] imm;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] first_rd;
    int          lat;
    int          nrd;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  // Waits for instr_valid (bounded), recording the opcode byte, reads and latency.
  task automatic wait_valid(output int lat, output logic [7:0] op,
                            output logic [15:0] rd_first, output logic [15:0] rd_last,
                            output int nrd);
    logic done;
    done = 1'b0; lat = -1; op = 'x; rd_first = 'x; rd_last = 'x; nrd = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.ir_load) op = bus.ir_data;
      if (bus.mem_rd) begin
        if (nrd == 0) rd_first = bus.mem_addr;
        rd_last = bus.mem_addr;
        nrd++;
      end
      if (bus.instr_valid) begin
        lat  = k;
        done = 1'b1;
      end
    end
    if (!done) check("valid_timeout", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_rd"},   {31'd0, bus.mem_rd},      32'd0);
    check({tag, "_mem_addr"}, {16'd0, bus.mem_addr},    32'h0000);
    check({tag, "_pc"},       {16'd0, bus.pc},          32'h0000);
    check({tag, "_ir_load"},  {31'd0, bus.ir_load},     32'd0);
    check({tag, "_imm"},      {16'd0, bus.imm},         32'h0000);
    check({tag, "_valid"},    {31'd0, bus.instr_valid}, 32'd0);
    check({tag, "_illegal"},  {31'd0, bus.illegal_op},  32'd0);
  endtask

  initial begin
    int          lat, nrd;
    logic [7:0]  op;
    logic [15:0] rf, rl;
    exp_t        e;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h08;  // 1-byte opcode 0x01
    reset            = 1'b1;
    bus.instr_ready  = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_addr = '0;

    vecs[0] = '{16'h0010, 8'hC0, 8'h34, 8'h12, 3, 16'h1234};
    vecs[1] = '{16'h0013, 8'h80, 8'h5A, 8'h00, 2, 16'h005A};
    vecs[2] = '{16'h0015, 8'h08, 8'h00, 8'h00, 1, 16'h0000};
    vecs[3] = '{16'h0016, 8'hC8, 8'hFF, 8'h00, 3, 16'h00FF};
    vecs[4] = '{16'h0019, 8'h97, 8'hA5, 8'h00, 2, 16'h00A5};
    vecs[5] = '{16'h001B, 8'hC0, 8'hEF, 8'hBE, 3, 16'hBEEF};
    foreach (vecs[i]) begin
      mem[vecs[i].addr] = vecs[i].b0;
      if (vecs[i].len > 1) mem[16'(vecs[i].addr + 1)] = vecs[i].b1;
      if (vecs[i].len > 2) mem[16'(vecs[i].addr + 2)] = vecs[i].b2;
      sb.push_back('{vecs[i].b0, vecs[i].imm, 16'(vecs[i].addr + 16'(vecs[i].len)),
                     vecs[i].addr, 2 * vecs[i].len, vecs[i].len});
    end
    mem[16'hFFFF] = 8'h80;   // 2-byte opcode straddling the wrap; operand is mem[0]=0x08
    mem[16'h0001] = 8'hF0;   // undefined opcode 0x1E

    // Reset state, then first instruction at the reset vector.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("c1_mem_rd",   {31'd0, bus.mem_rd},      32'd1);
    check("c1_mem_addr", {16'd0, bus.mem_addr},    32'h0000);
    @(negedge clk);
    check("c2_ir_load",  {31'd0, bus.ir_load},     32'd1);
    check("c2_ir_data",  {24'd0, bus.ir_data},     32'h08);
    @(negedge clk);
    check("c3_valid",    {31'd0, bus.instr_valid}, 32'd1);
    check("c3_pc",       {16'd0, bus.pc},          32'h0001);

    // Redirect during the handshake into the instruction table.
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'h0010;
    @(posedge clk);
    #1 bus.pc_load = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wait_valid(lat, op, rf, rl, nrd);
      e = sb.pop_front();
      check($sformatf("v%0d_op", i),       {24'd0, op},      {24'd0, e.op});
      check($sformatf("v%0d_imm", i),      {16'd0, bus.imm}, {16'd0, e.imm});
      check($sformatf("v%0d_pc", i),       {16'd0, bus.pc},  {16'd0, e.pc});
      check($sformatf("v%0d_first_rd", i), {16'd0, rf},      {16'd0, e.first_rd});
      check($sformatf("v%0d_latency", i),  lat,              e.lat);
      check($sformatf("v%0d_reads", i),    nrd,              e.nrd);
    end

    // Stall: consumer not ready for 5 cycles while 0xBEEF is presented.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i),  {31'd0, bus.instr_valid}, 32'd1);
      check($sformatf("hold%0d_imm", i),    {16'd0, bus.imm},         32'hBEEF);
      check($sformatf("hold%0d_mem_rd", i), {31'd0, bus.mem_rd},      32'd0);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("resume_mem_rd",   {31'd0, bus.mem_rd},   32'd1);
    check("resume_mem_addr", {16'd0, bus.mem_addr}, 32'h001E);

    // pc_load outside the handshake is ignored; inside it redirects.
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'h4000;
    bus.instr_ready  = 1'b0;
    @(negedge clk);
    check("ign_pc_wait",    {16'd0, bus.pc},          32'h001F);
    @(negedge clk);
    check("ign_valid",      {31'd0, bus.instr_valid}, 32'd1);
    check("ign_pc_present", {16'd0, bus.pc},          32'h001F);
    bus.pc_load_addr = 16'h8000;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    check("jmp_mem_rd",   {31'd0, bus.mem_rd},   32'd1);
    check("jmp_mem_addr", {16'd0, bus.mem_addr}, 32'h8000);
    bus.pc_load = 1'b0;
    wait_valid(lat, op, rf, rl, nrd);
    check("jmp_op", {24'd0, op}, 32'h08);

    // 2-byte instruction straddling 0xFFFF -> 0x0000.
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 16'hFFFF;
    @(posedge clk);
    #1 bus.pc_load = 1'b0;
    wait_valid(lat, op, rf, rl, nrd);
    check("wrap_op",      {24'd0, op},      32'h80);
    check("wrap_rd_op",   {16'd0, rf},      32'hFFFF);
    check("wrap_rd_b1",   {16'd0, rl},      32'h0000);
    check("wrap_reads",   nrd,              32'd2);
    check("wrap_latency", lat,              32'd4);
    check("wrap_imm",     {16'd0, bus.imm}, 32'h0008);
    check("wrap_pc",      {16'd0, bus.pc},  32'h0001);

    // Undefined opcode at 0x0001.
`ifdef FETCH_ILLEGAL_TRAP_EN
    op = 'x; nrd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ir_load) op = bus.ir_data;
      if (bus.mem_rd) nrd++;
    end
    check("trap_op",      {24'd0, op},              32'hF0);
    check("trap_reads",   nrd,                      32'd1);
    check("trap_illegal", {31'd0, bus.illegal_op},  32'd1);
    check("trap_valid",   {31'd0, bus.instr_valid}, 32'd0);
    check("trap_pc",      {16'd0, bus.pc},          32'h0002);
`else
    wait_valid(lat, op, rf, rl, nrd);
    check("undef_op",      {24'd0, op},             32'hF0);
    check("undef_latency", lat,                     32'd2);
    check("undef_imm",     {16'd0, bus.imm},        32'h0000);
    check("undef_illegal", {31'd0, bus.illegal_op}, 32'd0);
    check("undef_pc",      {16'd0, bus.pc},         32'h0002);
`endif

    // Reset asserted while waiting for operand byte 1 of a 2-byte instruction.
    mem[16'h0000] = 8'h80;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rb1_fetch_addr", {16'd0, bus.mem_addr}, 32'h0000);
    @(negedge clk);
    @(negedge clk);
    check("rb1_b1_addr",    {16'd0, bus.mem_addr}, 32'h0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rb1");
    @(posedge clk);
    #1 reset = 1'b0;
    wait_valid(lat, op, rf, rl, nrd);
    check("post_rst_op",      {24'd0, op},      32'h80);
    check("post_rst_latency", lat,              32'd4);
    check("post_rst_imm",     {16'd0, bus.imm}, 32'h00F0);
    check("post_rst_pc",      {16'd0, bus.pc},  32'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
